regfile_write_arbiter: RTL and testbench

- Shares the single write port of the 32x32 register file between two writeback requesters: req0 (ALU writeback) and req1 (load/memory writeback).
- The register file is built from enabled D flip-flops. This block drives the one-hot per-register enable bus and the shared write-data bus into it.
- Arbitration is round-robin. Grant is a same-cycle handshake, and the write pulse is registered one cycle later.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_addr_decoder.sv | 13 +
 rtl/regfile_write_arbiter.sv | 75 +++++++
 tb/tb_regfile_write_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared constants for the register-file write arbiter: sizes, FSM state codes,
// and the hardwired-zero register index.
package regfile_pkg;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREG   = 32;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WR0  = 2'd1;
    localparam logic [1:0] ST_WR1  = 2'd2;

    localparam logic [ADDR_W-1:0] REG_ZERO = '0;
endpackage

// File: rtl/regfile_addr_decoder.sv
// Combinational address to one-hot decoder; a low enable forces every output bit to 0.
module regfile_addr_decoder #(
    parameter int AW = regfile_pkg::ADDR_W,
    parameter int N  = regfile_pkg::NREG
) (
    input  logic          en,
    input  logic [AW-1:0] addr,
    output logic [N-1:0]  onehot
);
    for (genvar i = 0; i < N; i++) begin : g_dec
        assign onehot[i] = en && (addr == AW'(i));
    end
endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter for the single register-file write port.
// Grants are combinational; the one-hot enable and data are registered one cycle later.
module regfile_write_arbiter
    import regfile_pkg::ST_IDLE, regfile_pkg::ST_WR0, regfile_pkg::ST_WR1, regfile_pkg::REG_ZERO;
#(
    parameter int DATA_W = regfile_pkg::DATA_W,
    parameter int ADDR_W = regfile_pkg::ADDR_W,
    parameter int NREG   = regfile_pkg::NREG
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [DATA_W-1:0] data0,
    output logic              gnt0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] data1,
    output logic              gnt1,
    output logic [NREG-1:0]   wr_en,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_src,
    output logic              conflict
);
    logic              rr_last;
    logic [1:0]        state;
    logic              src_q;
    logic [NREG-1:0]   en_q;
    logic [NREG-1:0]   dec;
    logic              any_gnt;
    logic              contend;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;

    // Grants are suppressed while reset is held so nothing looks accepted during reset.
    assign contend  = reset & ~stall & req0 & req1;
    assign gnt0     = reset & ~stall & req0 & (~req1 | rr_last);
    assign gnt1     = reset & ~stall & req1 & (~req0 | ~rr_last);
    assign any_gnt  = gnt0 | gnt1;
    assign gnt_addr = gnt1 ? addr1 : addr0;
    assign gnt_data = gnt1 ? data1 : data0;

    regfile_addr_decoder #(.AW(ADDR_W), .N(NREG)) u_dec (
        .en     (any_gnt && (gnt_addr != REG_ZERO)),
        .addr   (gnt_addr),
        .onehot (dec)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_q     <= '0;
            wr_data  <= '0;
            src_q    <= 1'b0;
            conflict <= 1'b0;
            rr_last  <= 1'b1;
            state    <= ST_IDLE;
        end else begin
            conflict <= contend;
            en_q     <= dec;
            if (any_gnt) begin
                wr_data <= gnt_data;
                src_q   <= gnt1;
                rr_last <= gnt1;
                state   <= gnt1 ? ST_WR1 : ST_WR0;
            end else begin
                state   <= ST_IDLE;
            end
        end
    end

    // Pulse validity and source come from the state; the source holds while idle.
    assign wr_en  = (state != ST_IDLE) ? en_q : '0;
    assign wr_src = (state == ST_WR1) | ((state == ST_IDLE) & src_q);
endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed bench: stimulus pushes hand-computed expected outputs into a queue,
// a negedge monitor pops and compares them in the cycle they are due.
module tb_regfile_write_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic        req0, req1;
    logic [4:0]  addr0, addr1;
    logic [31:0] data0, data1;
    logic        gnt0, gnt1;
    logic [31:0] wr_en;
    logic [31:0] wr_data;
    logic        wr_src;
    logic        conflict;

    int tests  = 0;
    int failed = 0;
    int cyc    = 0;

    typedef struct {
        int          cyc;
        logic [31:0] en;
        logic [31:0] data;
        logic        src;
        logic        conf;
    } exp_t;
    exp_t q[$];

    regfile_write_arbiter dut (
        .clk(clk), .reset(reset), .stall(stall),
        .req0(req0), .addr0(addr0), .data0(data0), .gnt0(gnt0),
        .req1(req1), .addr1(addr1), .data1(data1), .gnt1(gnt1),
        .wr_en(wr_en), .wr_data(wr_data), .wr_src(wr_src), .conflict(conflict)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0 && q[0].cyc <= cyc) begin
            exp_t e;
            e = q.pop_front();
            if (e.cyc != cyc) begin
                tests++;
                failed++;
                $display("FAIL stale_expect: got cycle %0d want cycle %0d", cyc, e.cyc);
            end else begin
                chk("wr_en",    wr_en,           e.en);
                chk("wr_data",  wr_data,         e.data);
                chk("wr_src",   {31'd0, wr_src}, {31'd0, e.src});
                chk("conflict", {31'd0, conflict}, {31'd0, e.conf});
            end
        end
    end

    // Called at posedge+1: drive inputs, check grants, queue the next-cycle outputs.
    task automatic step(input logic r0, input logic [4:0] a0, input logic [31:0] d0,
                        input logic r1, input logic [4:0] a1, input logic [31:0] d1,
                        input logic st, input logic eg0, input logic eg1,
                        input logic [31:0] een, input logic [31:0] edata,
                        input logic esrc, input logic econf, input logic push);
        exp_t e;
        req0 = r0; addr0 = a0; data0 = d0;
        req1 = r1; addr1 = a1; data1 = d1;
        stall = st;
        #3;
        chk("gnt0", {31'd0, gnt0}, {31'd0, eg0});
        chk("gnt1", {31'd0, gnt1}, {31'd0, eg1});
        if (push) begin
            e.cyc = cyc + 1; e.en = een; e.data = edata; e.src = esrc; e.conf = econf;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] A0 = 32'hA0A0_0003, B1 = 32'hB1B1_0007;
    localparam logic [31:0] C0 = 32'hC0C0_0003, C1 = 32'hC1C1_0007;
    localparam logic [31:0] E0 = 32'hE0E0_0009, E1 = 32'hE1E1_0009;
    localparam logic [31:0] F0 = 32'hF0F0_0005, DB = 32'hDEAD_BEEF;

    initial begin
        reset = 1'b0; stall = 1'b0;
        req0 = 1'b1; addr0 = 5'd5; data0 = DB;
        req1 = 1'b0; addr1 = '0;   data1 = '0;
        repeat (3) begin
            @(negedge clk);
            chk("rst_wr_en",   wr_en, 32'h0);
            chk("rst_wr_data", wr_data, 32'h0);
            chk("rst_gnt",     {30'd0, gnt1, gnt0}, 32'h0);
            chk("rst_misc",    {30'd0, wr_src, conflict}, 32'h0);
        end
        @(posedge clk); #1;
        reset = 1'b1;

        // contention right after reset: req0 first, then alternating
        step(1, 3, A0, 1, 7, B1, 0, 1, 0, 32'h8,  A0, 0, 1, 1);
        step(1, 3, A0, 1, 7, B1, 0, 0, 1, 32'h80, B1, 1, 1, 1);
        step(1, 3, A0, 1, 7, B1, 0, 1, 0, 32'h8,  A0, 0, 1, 1);
        step(1, 3, A0, 1, 7, B1, 0, 0, 1, 32'h80, B1, 1, 1, 1);
        step(0, 0, 0,  0, 0, 0,  0, 0, 0, 32'h0,  B1, 1, 0, 1);
        // single uncontended write, then the pulse ends
        step(1, 5, DB, 0, 0, 0,  0, 1, 0, 32'h20, DB, 0, 0, 1);
        step(0, 0, 0,  0, 0, 0,  0, 0, 0, 32'h0,  DB, 0, 0, 1);
        // write to register 0: data captured, no enable
        step(0, 0, 0,  1, 0, 32'h1234, 0, 0, 1, 32'h0, 32'h1234, 1, 0, 1);
        step(0, 0, 0,  0, 0, 0,  0, 0, 0, 32'h0,  32'h1234, 1, 0, 1);
        // stall: nothing granted, order resumes as before
        step(1, 3, C0, 1, 7, C1, 1, 0, 0, 32'h0,  32'h1234, 1, 0, 1);
        step(1, 3, C0, 1, 7, C1, 1, 0, 0, 32'h0,  32'h1234, 1, 0, 1);
        step(1, 3, C0, 1, 7, C1, 1, 0, 0, 32'h0,  32'h1234, 1, 0, 1);
        step(1, 3, C0, 1, 7, C1, 0, 1, 0, 32'h8,  C0, 0, 1, 1);
        step(1, 3, C0, 1, 7, C1, 0, 0, 1, 32'h80, C1, 1, 1, 1);
        // same destination: serialized back-to-back
        step(1, 9, E0, 1, 9, E1, 0, 1, 0, 32'h200, E0, 0, 1, 1);
        step(1, 9, E0, 1, 9, E1, 0, 0, 1, 32'h200, E1, 1, 1, 1);
        step(0, 0, 0,  0, 0, 0,  0, 0, 0, 32'h0,   E1, 1, 0, 1);
        // async reset in the middle of a pulse
        step(1, 5, F0, 0, 0, 0,  0, 1, 0, 32'h0,  32'h0, 0, 0, 0);
        req0 = 1'b0;
        #1 chk("pre_rst_wr_en", wr_en, 32'h20);
        #1 reset = 1'b0;
        #1 chk("async_wr_en", wr_en, 32'h0);
        chk("async_wr_data", wr_data, 32'h0);
        @(posedge clk); #1;
        reset = 1'b1;
        step(1, 3, A0, 1, 7, B1, 0, 1, 0, 32'h8,  A0, 0, 1, 1);
        step(0, 0, 0,  0, 0, 0,  0, 0, 0, 32'h0,  A0, 0, 0, 1);
        repeat (2) @(posedge clk);
        #1 chk("queue_drained", q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
